cube_check: RTL and testbench
=============================

Name: cube_check

Overview:
- Downstream verification stage of the cube controller; runs while the controller sits in its CHECK state.
- On a start pulse it snapshots the full 54-facelet cube colour vector and scans it facelet-by-facelet against each face's centre colour.
- Reports solved/unsolved, a mismatch count and an illegal-colour error, then emits a one-cycle done pulse that drives the controller's load input.

Parameters:
- LANES, 1, facelets compared per scan cycle; legal values 1, 3, 9 (must divide 9); other values are a compile-time error.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle request; sampled only in IDLE.
- cube_in  input  162  54 facelets x 3 bits; facelet i at bits [3i+2:3i]; face f = facelets 9f..9f+8; centre of face f = facelet 9f+4.
- busy  output  1  high in every state other than IDLE.
- done  output  1  one-cycle pulse when results are valid; feeds the controller's load.
- solved  output  1  1 = every facelet equals its face centre and no illegal code; held until the next start.
- mismatch_cnt  output  6  number of non-centre facelets differing from their centre (0..48); held until the next start.
- err  output  1  any facelet code > 5 (centres included); held until the next start.

Behaviour:
- Reset values: busy=0, done=0, solved=0, mismatch_cnt=0, err=0, FSM=IDLE, index=0, snapshot=0.
- FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN on start=1. The same edge captures cube_in into the snapshot, sets index=0, and clears the count and error accumulators.
  - SCAN: each cycle compares facelets index..index+LANES-1 against the centre of their face, taken from the snapshot. Index advances by LANES. SCAN -> DONE after the cycle that processes facelet 53.
  - DONE: done=1 for exactly one cycle, and solved/mismatch_cnt/err update to the final values on entry. DONE -> IDLE unconditionally.
- Latency: start sampled at edge 0; SCAN occupies 54/LANES cycles; done is high in the cycle starting at edge 54/LANES+1. This gives 55 cycles for LANES=1, 19 for LANES=3, 7 for LANES=9.
- Comparison rules:
  - A centre facelet never counts as a mismatch, but an illegal centre code (6 or 7) sets err.
  - A facelet with an illegal code counts as a mismatch and sets err.
  - If the centre itself is illegal, every non-centre facelet on that face counts as a mismatch.
- Results: solved = (mismatch_cnt==0) && !err. mismatch_cnt saturates at 48; it cannot exceed that with legal geometry.
- Input timing: cube_in is ignored after the snapshot edge, so changes during SCAN have no effect.
- start while busy (SCAN or DONE) is ignored and not queued. start in the cycle after DONE (IDLE) is accepted normally, so back-to-back checks are possible with a one-cycle IDLE gap.
- Outputs solved/mismatch_cnt/err keep their previous result during SCAN and change only on entry to DONE.
- Reset mid-scan: immediate return to IDLE with all reset values. No done pulse is produced for the aborted check.
- Unreachable FSM encodings return to IDLE on the next edge.

Optional Feature:
- Macro CUBE_CHECK_EARLY_EXIT_EN.
- Defined: SCAN -> DONE after the first cycle that finds any mismatch or illegal code. mismatch_cnt then reports only the mismatches found in that cycle (1..LANES), err reflects only the facelets scanned so far, and solved=0. The solved-cube latency is unchanged.
- Undefined: the full scan always runs, and mismatch_cnt is the exact total.

Test Plan:
- Solved cube (face f all colour f), LANES=1, start pulse -> busy high for 56 cycles, done pulse 55 cycles after the start edge, solved=1, mismatch_cnt=0, err=0.
- Single 3-bit swap of facelets 0 and 9 (colours 1 and 0) -> solved=0, mismatch_cnt=2, err=0. With CUBE_CHECK_EARLY_EXIT_EN: done after 2 SCAN cycles, mismatch_cnt=1.
- Facelet 20 set to 7, rest solved -> err=1, solved=0, mismatch_cnt=1. Centre 13 set to 6 -> err=1, mismatch_cnt=8.
- start re-pulsed during SCAN and during DONE, with cube_in changed mid-scan -> ignored; results match the snapshot; exactly one done pulse. A start the cycle after DONE starts a new check.
- rst_n low at SCAN cycle 20 -> all outputs 0 immediately, no done pulse. A following start on a solved cube gives a normal result.
- LANES=9 and LANES=3 on the solved cube and the 2-mismatch cube -> done at 7 and 19 cycles respectively, with results identical to LANES=1.

Source files
------------

// File: rtl/cube_check_if.sv
// Request/result bundle between the cube controller and cube_check.
// The controller is master; the checker is slave.
interface cube_check_if;
  logic         start;
  logic [161:0] cube_in;
  logic         busy;
  logic         done;
  logic         solved;
  logic [5:0]   mismatch_cnt;
  logic         err;

  modport master (
    output start, cube_in,
    input  busy, done, solved, mismatch_cnt, err
  );

  modport slave (
    input  start, cube_in,
    output busy, done, solved, mismatch_cnt, err
  );
endinterface

// File: rtl/cube_check.sv
// Snapshot-and-scan verifier for the 54-facelet cube, LANES facelets/cycle.
// Define CUBE_CHECK_EARLY_EXIT_EN to stop at the first bad scan cycle.
module cube_check #(
  parameter int LANES = 1
) (
  input  logic clk,
  input  logic rst_n,
  cube_check_if.slave bus
);

  if (LANES != 1 && LANES != 3 && LANES != 9) begin : g_bad_lanes
    $error("cube_check: LANES must be 1, 3 or 9");
  end

  localparam logic [3:0] LSTEP    = 4'(LANES);
  localparam logic [3:0] LAST_POS = 4'(9 - LANES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [161:0] snap_q, snap_d;
  logic [2:0]   face_q, face_d;
  logic [3:0]   pos_q, pos_d;
  logic         issue_q, issue_d;
  logic         pv_q, pv_d;
  logic [3:0]   pcnt_q, pcnt_d;
  logic         perr_q, perr_d;
  logic         plast_q, plast_d;
  logic [5:0]   acc_q, acc_d;
  logic         eacc_q, eacc_d;
  logic         solved_q, solved_d;
  logic [5:0]   mcnt_q, mcnt_d;
  logic         err_q, err_d;

  logic [7:0]       ctr_idx;
  logic [7:0]       lane_base;
  logic [2:0]       ctr;
  logic             ctr_ill;
  logic [2:0]       lane_code [LANES];
  logic [LANES-1:0] lane_mis;
  logic [LANES-1:0] lane_ill;
  logic [3:0]       lane_cnt;
  logic             lane_err;
  logic             last_issue;
  logic [6:0]       sum;
  logic [5:0]       sum_sat;

  assign ctr_idx    = 8'(face_q) * 8'd27 + 8'd12;
  assign lane_base  = 8'(face_q) * 8'd27 + 8'(pos_q) * 8'd3;
  assign last_issue = (face_q == 3'd5) && (pos_q == LAST_POS);

  // All lanes of one cycle lie on the same face since LANES divides 9.
  always_comb begin
    ctr      = snap_q[ctr_idx +: 3];
    ctr_ill  = ctr > 3'd5;
    lane_cnt = '0;
    lane_err = 1'b0;
    lane_mis = '0;
    lane_ill = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_code[l] = snap_q[lane_base + 8'(3 * l) +: 3];
      lane_ill[l]  = lane_code[l] > 3'd5;
      lane_mis[l]  = ((pos_q + 4'(l)) != 4'd4) &&
                     (lane_ill[l] || ctr_ill ||
                      (lane_code[l] != ctr));
      lane_cnt     = lane_cnt + 4'(lane_mis[l]);
      lane_err     = lane_err | lane_ill[l];
    end
  end

  always_comb begin
    sum     = {1'b0, acc_q} + 7'(pcnt_q);
    sum_sat = (sum > 7'd48) ? 6'd48 : sum[5:0];
  end

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    face_d   = face_q;
    pos_d    = pos_q;
    issue_d  = issue_q;
    pv_d     = pv_q;
    pcnt_d   = pcnt_q;
    perr_d   = perr_q;
    plast_d  = plast_q;
    acc_d    = acc_q;
    eacc_d   = eacc_q;
    solved_d = solved_q;
    mcnt_d   = mcnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          snap_d  = bus.cube_in;
          face_d  = '0;
          pos_d   = '0;
          issue_d = 1'b1;
          pv_d    = 1'b0;
          acc_d   = '0;
          eacc_d  = 1'b0;
        end
      end
      SCAN: begin
        // Compare stage feeds a one-deep accumulate stage.
        pv_d = issue_q;
        if (issue_q) begin
          pcnt_d  = lane_cnt;
          perr_d  = lane_err;
          plast_d = last_issue;
          if (last_issue) begin
            issue_d = 1'b0;
          end else if (pos_q == LAST_POS) begin
            pos_d  = '0;
            face_d = face_q + 3'd1;
          end else begin
            pos_d = pos_q + LSTEP;
          end
        end
        if (pv_q) begin
          acc_d  = sum_sat;
          eacc_d = eacc_q | perr_q;
`ifdef CUBE_CHECK_EARLY_EXIT_EN
          if (pcnt_q != 4'd0 || perr_q) begin
            state_d  = DONE;
            issue_d  = 1'b0;
            mcnt_d   = {2'b00, pcnt_q};
            err_d    = eacc_q | perr_q;
            solved_d = 1'b0;
          end else if (plast_q) begin
            state_d  = DONE;
            mcnt_d   = sum_sat;
            err_d    = eacc_q | perr_q;
            solved_d = (sum_sat == 6'd0) && !(eacc_q | perr_q);
          end
`else
          if (plast_q) begin
            state_d  = DONE;
            mcnt_d   = sum_sat;
            err_d    = eacc_q | perr_q;
            solved_d = (sum_sat == 6'd0) && !(eacc_q | perr_q);
          end
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      face_q   <= '0;
      pos_q    <= '0;
      issue_q  <= 1'b0;
      pv_q     <= 1'b0;
      pcnt_q   <= '0;
      perr_q   <= 1'b0;
      plast_q  <= 1'b0;
      acc_q    <= '0;
      eacc_q   <= 1'b0;
      solved_q <= 1'b0;
      mcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      face_q   <= face_d;
      pos_q    <= pos_d;
      issue_q  <= issue_d;
      pv_q     <= pv_d;
      pcnt_q   <= pcnt_d;
      perr_q   <= perr_d;
      plast_q  <= plast_d;
      acc_q    <= acc_d;
      eacc_q   <= eacc_d;
      solved_q <= solved_d;
      mcnt_q   <= mcnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.solved       = solved_q;
  assign bus.mismatch_cnt = mcnt_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_cube_check.sv
// Bench for cube_check: LANES=1/3/9 instances driven side by side,
// table vectors, random cubes against a facelet-rule model, corner sequences.
module tb_cube_check;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cube_check_if if1 ();
  cube_check_if if3 ();
  cube_check_if if9 ();

  logic [2:0]   st;
  logic [161:0] cube;

  assign if1.start   = st[0];
  assign if3.start   = st[1];
  assign if9.start   = st[2];
  assign if1.cube_in = cube;
  assign if3.cube_in = cube;
  assign if9.cube_in = cube;

  cube_check #(.LANES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  cube_check #(.LANES(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  cube_check #(.LANES(9)) u9 (.clk(clk), .rst_n(rst_n), .bus(if9));

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    logic [161:0] cube;
    int           mc;
    logic         er;
    logic         sv;
  } vec_t;

  vec_t tab [7];

  function automatic int lanes_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 9;
  endfunction

  task automatic samp(input int i, output logic d, output logic b,
                      output logic s, output logic e,
                      output logic [5:0] m);
    case (i)
      0: begin
        d = if1.done; b = if1.busy; s = if1.solved;
        e = if1.err;  m = if1.mismatch_cnt;
      end
      1: begin
        d = if3.done; b = if3.busy; s = if3.solved;
        e = if3.err;  m = if3.mismatch_cnt;
      end
      default: begin
        d = if9.done; b = if9.busy; s = if9.solved;
        e = if9.err;  m = if9.mismatch_cnt;
      end
    endcase
  endtask

  task automatic chk(input string nm, input int i,
                     input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s LANES=%0d got %0d want %0d",
               nm, lanes_of(i), act, exp);
    end
  endtask

  function automatic logic [161:0] solved_cube(input int rot);
    logic [161:0] c;
    c = '0;
    for (int j = 0; j < 54; j++) c[3*j +: 3] = 3'((j / 9 + rot) % 6);
    return c;
  endfunction

  function automatic logic [161:0] setf(input logic [161:0] c,
                                        input int j, input int v);
    logic [161:0] r;
    r = c;
    r[3*j +: 3] = 3'(v);
    return r;
  endfunction

  // Facelet rules applied directly; scan grouped into LANES-wide cycles.
  function automatic void model(input logic [161:0] c, input int ln,
                                output int mc, output logic er,
                                output logic sv, output int lat);
    int cm;
    logic ce;
    int j;
    logic [2:0] code, ctr;
    mc = 0; er = 1'b0; sv = 1'b0; lat = 54 / ln + 1;
    for (int k = 0; k < 54 / ln; k++) begin
      cm = 0; ce = 1'b0;
      for (int l = 0; l < ln; l++) begin
        j    = k * ln + l;
        code = c[3*j +: 3];
        ctr  = c[3*((j / 9) * 9 + 4) +: 3];
        if (code > 5) ce = 1'b1;
        if (j % 9 != 4 && (code != ctr || code > 5 || ctr > 5)) cm++;
      end
`ifdef CUBE_CHECK_EARLY_EXIT_EN
      if (cm != 0 || ce) begin
        mc = cm; er = er | ce; sv = 1'b0; lat = k + 2;
        return;
      end
`endif
      mc += cm;
      er |= ce;
    end
    if (mc > 48) mc = 48;
    sv = (mc == 0) && !er;
  endfunction

  task automatic run_check(input logic [161:0] c, input string nm,
                           input logic has_exp, input int emc,
                           input logic eer, input logic esv);
    logic d, b, s, e;
    logic [5:0] m;
    logic [5:0] prevm [3];
    int dcnt [3];
    int dlat [3];
    int rmc [3];
    logic rer [3];
    logic rsv [3];
    int xmc, xlat;
    logic xer, xsv;
    @(negedge clk);
    cube = c;
    st   = 3'b111;
    for (int i = 0; i < 3; i++) begin
      samp(i, d, b, s, e, m);
      prevm[i] = m;
      dcnt[i] = 0; dlat[i] = -1;
      rmc[i] = -1; rer[i] = 1'b0; rsv[i] = 1'b0;
    end
    @(posedge clk);
    #1 st = 3'b000;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        samp(i, d, b, s, e, m);
        if (n == 1) begin
          chk({nm, " busy"}, i, b, 1);
          chk({nm, " held_cnt"}, i, m, prevm[i]);
        end
        if (d) begin
          dcnt[i]++;
          if (dcnt[i] == 1) begin
            dlat[i] = n; rmc[i] = m; rer[i] = e; rsv[i] = s;
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      model(c, lanes_of(i), xmc, xer, xsv, xlat);
`ifndef CUBE_CHECK_EARLY_EXIT_EN
      if (has_exp) begin
        xmc = emc; xer = eer; xsv = esv;
      end
`endif
      samp(i, d, b, s, e, m);
      chk({nm, " dones"}, i, dcnt[i], 1);
      chk({nm, " latency"}, i, dlat[i], xlat);
      chk({nm, " mismatch_cnt"}, i, rmc[i], xmc);
      chk({nm, " err"}, i, rer[i], xer);
      chk({nm, " solved"}, i, rsv[i], xsv);
      chk({nm, " idle_busy"}, i, b, 0);
    end
  endtask

  task automatic seq_repulse();
    logic d, b, s, e;
    logic [5:0] m;
    logic [161:0] c_a, c_b;
    int elat [3];
    int xmc [3];
    logic xer [3], xsv [3];
    int l2 [3];
    int mc2 [3];
    logic er2 [3], sv2 [3];
    int dcnt [3];
    int t [3][2];
    int gm [3][2];
    logic ge [3][2], gs [3][2];
    c_a = setf(setf(solved_cube(0), 0, 1), 9, 0);
    c_b = '1;
    for (int i = 0; i < 3; i++) begin
      model(c_a, lanes_of(i), xmc[i], xer[i], xsv[i], elat[i]);
      model(c_b, lanes_of(i), mc2[i], er2[i], sv2[i], l2[i]);
      dcnt[i] = 0;
    end
    for (int n = 0; n <= 131; n++) begin
      @(negedge clk);
      if (n >= 1) begin
        for (int i = 0; i < 3; i++) begin
          samp(i, d, b, s, e, m);
          if (d) begin
            if (dcnt[i] < 2) begin
              t[i][dcnt[i]] = n - 1; gm[i][dcnt[i]] = m;
              ge[i][dcnt[i]] = e; gs[i][dcnt[i]] = s;
            end
            dcnt[i]++;
          end
        end
      end
      cube = (n < 3) ? c_a : c_b;
      for (int i = 0; i < 3; i++)
        st[i] = (n == 0) || (n == 3) || (n == elat[i] + 1) ||
                (n == elat[i] + 2);
    end
    st = 3'b000;
    for (int i = 0; i < 3; i++) begin
      chk("repulse dones", i, dcnt[i], 2);
      if (dcnt[i] >= 1) begin
        chk("repulse t1", i, t[i][0], elat[i]);
        chk("repulse cnt1", i, gm[i][0], xmc[i]);
        chk("repulse err1", i, ge[i][0], xer[i]);
        chk("repulse solved1", i, gs[i][0], xsv[i]);
      end
      if (dcnt[i] >= 2) begin
        chk("b2b t2", i, t[i][1], elat[i] + 2 + l2[i]);
        chk("b2b cnt2", i, gm[i][1], mc2[i]);
        chk("b2b err2", i, ge[i][1], er2[i]);
      end
    end
  endtask

  task automatic seq_reset();
    logic d, b, s, e;
    logic [5:0] m;
    int dcnt;
    @(negedge clk);
    cube = setf(setf(solved_cube(0), 0, 1), 9, 0);
    st   = 3'b111;
    @(posedge clk);
    #1 st = 3'b000;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      samp(i, d, b, s, e, m);
      chk("midreset outs", i, {b, d, s, e, m}, 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        samp(i, d, b, s, e, m);
        if (d) dcnt++;
      end
    end
    chk("midreset no_done", 0, dcnt, 0);
    run_check(solved_cube(0), "post_reset", 1'b1, 0, 1'b0, 1'b1);
  endtask

  initial begin
    logic d, b, s, e;
    logic [5:0] m;
    logic [161:0] c;
    int k;

    tab[0] = '{solved_cube(0), 0, 1'b0, 1'b1};
    tab[1] = '{setf(setf(solved_cube(0), 0, 1), 9, 0), 2, 1'b0, 1'b0};
    tab[2] = '{setf(solved_cube(0), 20, 7), 1, 1'b1, 1'b0};
    tab[3] = '{setf(solved_cube(0), 13, 6), 8, 1'b1, 1'b0};
    tab[4] = '{solved_cube(1), 0, 1'b0, 1'b1};
    tab[5] = '{'1, 48, 1'b1, 1'b0};
    c = solved_cube(0);
    for (int j = 0; j < 9; j++) if (j != 4) c = setf(c, j, 3);
    tab[6] = '{c, 8, 1'b0, 1'b0};

    rst_n = 1'b0;
    st    = 3'b000;
    cube  = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      samp(i, d, b, s, e, m);
      chk("reset outs", i, {b, d, s, e, m}, 0);
    end
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++)
      run_check(tab[v].cube, $sformatf("tab%0d", v), 1'b1,
                tab[v].mc, tab[v].er, tab[v].sv);

    seq_repulse();
    seq_reset();

    for (int r = 0; r < 20; r++) begin
      if (r % 5 == 4) begin
        for (int j = 0; j < 54; j++)
          c[3*j +: 3] = 3'($urandom_range(0, 7));
      end else begin
        c = solved_cube($urandom_range(0, 5));
        k = $urandom_range(0, 4);
        for (int q = 0; q < k; q++)
          c = setf(c, $urandom_range(0, 53), $urandom_range(0, 7));
      end
      run_check(c, $sformatf("rand%0d", r), 1'b0, 0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
